// File: rtl/bounce_frame_ctrl.sv
// Per-frame sequencer for the color-bounce game: moves the ball on each frame tick, scores landings,
// strobes the game-state memory and handshakes with the VGA draw engine.
module bounce_frame_ctrl #(
    parameter logic [7:0] Y_TOP     = 8'd8,
    parameter logic [7:0] Y_FLOOR   = 8'd100,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        frame_tick,
    input  logic [1:0]  lane_sel,
    input  logic [11:0] color_plats_in,
    input  logic        draw_ack,
    output logic [7:0]  prev_ball,
    output logic [7:0]  curr_ball,
    output logic [2:0]  color_ball,
    output logic [11:0] score,
    output logic        mem_we,
    output logic        draw_req,
    output logic        game_over,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_TICK, S_MOVE, S_CHECK, S_COMMIT, S_DRAW, S_OVER
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  prev_q, prev_d;
    logic [7:0]  curr_q, curr_d;
    logic [2:0]  color_q, color_d;
    logic [11:0] score_q, score_d;
    logic        dir_up_q, dir_up_d;
    logic        over_q, over_d;
    logic [7:0]  lfsr_q, lfsr_d;

    logic [2:0]  lane_color [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_color[gi] = color_plats_in[3*gi +: 3];
        end
    endgenerate

    // Three-digit BCD increment that sticks at 999.
    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        if (v != 12'h999) begin
            if (r[3:0] == 4'd9) begin
                r[3:0] = 4'd0;
                if (r[7:4] == 4'd9) begin
                    r[7:4]  = 4'd0;
                    r[11:8] = r[11:8] + 4'd1;
                end else begin
                    r[7:4] = r[7:4] + 4'd1;
                end
            end else begin
                r[3:0] = r[3:0] + 4'd1;
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            prev_q   <= Y_TOP;
            curr_q   <= Y_TOP;
            color_q  <= 3'b111;
            score_q  <= 12'h000;
            dir_up_q <= 1'b0;
            over_q   <= 1'b0;
            lfsr_q   <= LFSR_SEED;
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            curr_q   <= curr_d;
            color_q  <= color_d;
            score_q  <= score_d;
            dir_up_q <= dir_up_d;
            over_q   <= over_d;
            lfsr_q   <= lfsr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (start) state_d = S_WAIT_TICK;
            S_WAIT_TICK: if (frame_tick) state_d = S_MOVE;
            S_MOVE:      state_d = S_CHECK;
            S_CHECK:     state_d = S_COMMIT;
            S_COMMIT:    state_d = S_DRAW;
            S_DRAW:      if (draw_ack) state_d = over_q ? S_OVER : S_WAIT_TICK;
            S_OVER:      if (start) state_d = S_WAIT_TICK;
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        prev_d   = prev_q;
        curr_d   = curr_q;
        color_d  = color_q;
        score_d  = score_q;
        dir_up_d = dir_up_q;
        over_d   = over_q;
        lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        case (state_q)
            S_MOVE: begin
                prev_d = curr_q;
                curr_d = dir_up_q ? curr_q - 8'd1 : curr_q + 8'd1;
            end
            S_CHECK: begin
                if (!dir_up_q && curr_q == Y_FLOOR) begin
                    if (color_q == lane_color[lane_sel]) begin
                        score_d  = bcd_inc(score_q);
                        dir_up_d = 1'b1;
                        color_d  = lane_color[lfsr_q[1:0]];
                    end else begin
                        over_d = 1'b1;
                    end
                end else if (dir_up_q && curr_q == Y_TOP) begin
                    dir_up_d = 1'b0;
                end
            end
            S_OVER: begin
                if (start) begin
                    prev_d   = Y_TOP;
                    curr_d   = Y_TOP;
                    color_d  = 3'b111;
                    score_d  = 12'h000;
                    dir_up_d = 1'b0;
                    over_d   = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        mem_we   = (state_q == S_COMMIT);
        draw_req = (state_q == S_DRAW);
        busy     = (state_q == S_MOVE) || (state_q == S_CHECK) ||
                   (state_q == S_COMMIT) || (state_q == S_DRAW);
    end

    assign prev_ball  = prev_q;
    assign curr_ball  = curr_q;
    assign color_ball = color_q;
    assign score      = score_q;
    assign game_over  = over_q;

endmodule

// File: tb/tb_bounce_frame_ctrl.sv
// Bench for bounce_frame_ctrl: a per-cycle reference model (integer score, phase names) checked on
// every falling edge, directed scenarios with literal expectations, then randomized traffic.
module tb_bounce_frame_ctrl;

    localparam int TOP   = 8;
    localparam int FLOOR = 10;

    logic        clk = 1'b0;
    logic        reset, start, frame_tick, draw_ack;
    logic [1:0]  lane_sel;
    logic [11:0] color_plats_in;
    logic [7:0]  prev_ball, curr_ball;
    logic [2:0]  color_ball;
    logic [11:0] score;
    logic        mem_we, draw_req, game_over, busy;

    bounce_frame_ctrl #(.Y_TOP(8'd8), .Y_FLOOR(8'd10), .LFSR_SEED(8'hA5)) dut (
        .clk(clk), .reset(reset), .start(start), .frame_tick(frame_tick),
        .lane_sel(lane_sel), .color_plats_in(color_plats_in), .draw_ack(draw_ack),
        .prev_ball(prev_ball), .curr_ball(curr_ball), .color_ball(color_ball),
        .score(score), .mem_we(mem_we), .draw_req(draw_req),
        .game_over(game_over), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef enum {P_IDLE, P_WAIT, P_MOVE, P_CHECK, P_COMMIT, P_DRAW, P_OVER} phase_t;

    phase_t     m_phase;
    int         m_prev, m_curr, m_color, m_score;
    bit         m_up, m_over;
    logic [7:0] m_lfsr;
    bit         chk_en = 1'b0;
    int         n_cmp = 0;
    int         n_bad = 0;

    function automatic int lane_of(input logic [11:0] plats, input int idx);
        return int'((plats >> (3 * idx)) & 12'h7);
    endfunction

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [11:0] fill(input logic [2:0] c);
        return {c, c, c, c};
    endfunction

    task automatic model_init();
        m_prev = TOP; m_curr = TOP; m_color = 7; m_score = 0; m_up = 0; m_over = 0;
    endtask

    // Advances the model by one clock using the inputs present at this rising edge.
    task automatic model_step();
        logic [7:0] nxt;
        if (!reset) begin
            model_init();
            m_phase = P_IDLE;
            m_lfsr  = 8'hA5;
            return;
        end
        nxt = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
        case (m_phase)
            P_IDLE: if (start) m_phase = P_WAIT;
            P_WAIT: if (frame_tick) m_phase = P_MOVE;
            P_MOVE: begin
                m_prev  = m_curr;
                m_curr  = m_up ? m_curr - 1 : m_curr + 1;
                m_phase = P_CHECK;
            end
            P_CHECK: begin
                if (!m_up && m_curr == FLOOR) begin
                    if (m_color == lane_of(color_plats_in, int'(lane_sel))) begin
                        m_score = (m_score < 999) ? m_score + 1 : 999;
                        m_up    = 1;
                        m_color = lane_of(color_plats_in, int'(m_lfsr[1:0]));
                    end else begin
                        m_over = 1;
                    end
                end else if (m_up && m_curr == TOP) begin
                    m_up = 0;
                end
                m_phase = P_COMMIT;
            end
            P_COMMIT: m_phase = P_DRAW;
            P_DRAW: if (draw_ack) m_phase = m_over ? P_OVER : P_WAIT;
            P_OVER: if (start) begin model_init(); m_phase = P_WAIT; end
            default: m_phase = P_IDLE;
        endcase
        m_lfsr = nxt;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("prev_ball", 32'(prev_ball), 32'(m_prev));
            chk("curr_ball", 32'(curr_ball), 32'(m_curr));
            chk("color_ball", 32'(color_ball), 32'(m_color));
            chk("score", 32'(score), 32'(to_bcd(m_score)));
            chk("mem_we", 32'(mem_we), 32'(m_phase == P_COMMIT));
            chk("draw_req", 32'(draw_req), 32'(m_phase == P_DRAW));
            chk("game_over", 32'(game_over), 32'(m_over));
            chk("busy", 32'(busy), 32'(m_phase inside {P_MOVE, P_CHECK, P_COMMIT, P_DRAW}));
        end
    end

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1; step(); start = 1'b0;
    endtask

    task automatic tick_to_draw();
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
        step(); step(); step();
    endtask

    task automatic ack_draw();
        draw_ack = 1'b1; step(); draw_ack = 1'b0;
    endtask

    task automatic frame();
        tick_to_draw();
        ack_draw();
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; frame_tick = 1'b0; draw_ack = 1'b0;
        lane_sel = 2'd0; color_plats_in = 12'h000;
        step();
        chk_en = 1'b1;
        step();
        reset = 1'b1;
        step();
        chk("rst_curr", 32'(curr_ball), 32'd8);
        chk("rst_color", 32'(color_ball), 32'd7);
        chk("rst_score", 32'(score), 32'h000);

        // Reset held two cycles in the middle of a draw handshake.
        pulse_start();
        tick_to_draw();
        chk("mid_draw_req", 32'(draw_req), 32'd1);
        reset = 1'b0; step(); step();
        chk("rst_draw_req", 32'(draw_req), 32'd0);
        chk("rst_curr2", 32'(curr_ball), 32'd8);
        chk("rst_color2", 32'(color_ball), 32'd7);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        step();
        pulse_start();

        // Tick-to-strobe latency of three edges.
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
        chk("lat_move_we", 32'(mem_we), 32'd0);
        step();
        chk("lat_check_we", 32'(mem_we), 32'd0);
        step();
        chk("lat_commit_we", 32'(mem_we), 32'd1);
        chk("first_curr", 32'(curr_ball), 32'd9);
        chk("first_prev", 32'(prev_ball), 32'd8);
        step();
        ack_draw();

        // start is ignored while waiting for a tick.
        pulse_start();
        chk("wait_start_busy", 32'(busy), 32'd0);
        chk("wait_start_curr", 32'(curr_ball), 32'd9);

        // Matching landing on lane 2 (white).
        lane_sel = 2'd2;
        color_plats_in = {3'b001, 3'b111, 3'b110, 3'b101};
        tick_to_draw();
        chk("land_curr", 32'(curr_ball), 32'd10);
        chk("land_score", 32'(score), 32'h001);
        ack_draw();
        frame();
        chk("bounce_curr", 32'(curr_ball), 32'd9);
        frame();
        chk("top_curr", 32'(curr_ball), 32'd8);
        frame();
        chk("top_rev_curr", 32'(curr_ball), 32'd9);
        chk("top_rev_score", 32'(score), 32'h001);

        // Mismatching landing ends the game.
        color_plats_in = fill(~color_ball);
        frame();
        chk("over_flag", 32'(game_over), 32'd1);
        chk("over_busy", 32'(busy), 32'd0);
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
        chk("over_tick_drop", 32'(curr_ball), 32'd10);
        pulse_start();
        chk("restart_score", 32'(score), 32'h000);
        chk("restart_curr", 32'(curr_ball), 32'd8);
        chk("restart_over", 32'(game_over), 32'd0);

        // Draw acknowledge withheld while ticks arrive.
        tick_to_draw();
        for (int i = 0; i < 20; i++) begin
            frame_tick = (i % 6 == 2);
            step();
        end
        frame_tick = 1'b0;
        chk("hold_draw_req", 32'(draw_req), 32'd1);
        chk("hold_curr", 32'(curr_ball), 32'd9);
        ack_draw();
        frame();
        chk("after_hold_curr", 32'(curr_ball), 32'd10);
        pulse_start();

        // Always-matching white lanes drive the score through the carries to saturation.
        color_plats_in = fill(3'b111);
        for (int f = 0; f < 1000 && m_score < 99; f++) frame();
        chk("score_099", 32'(score), 32'h099);
        for (int f = 0; f < 10 && m_score < 100; f++) frame();
        chk("score_100", 32'(score), 32'h100);
        for (int f = 0; f < 4000 && m_score < 999; f++) frame();
        chk("score_999", 32'(score), 32'h999);
        for (int f = 0; f < 4; f++) frame();
        chk("score_sat", 32'(score), 32'h999);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            reset          = ($urandom_range(0, 199) != 0);
            start          = ($urandom_range(0, 29) == 0);
            frame_tick     = ($urandom_range(0, 2) == 0);
            draw_ack       = ($urandom_range(0, 1) == 0);
            lane_sel       = 2'($urandom_range(0, 3));
            color_plats_in = 12'($urandom);
            step();
        end
        reset = 1'b1; start = 1'b0; frame_tick = 1'b0; draw_ack = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
